fifo_enq_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one FIFO enqueue port among NUM_REQ requesters
//  (e.g. dispatch lanes writing a shared issue/LSQ FIFO).

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/fifo_enq_rr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_enq_rr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin FIFO enqueue arbiter.
// Holds the arbiter state encoding, index/counter widths and the saturating increment helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    localparam int REQ_IDX_W      = 3;
    localparam int PERF_CTR_WIDTH = 16;
    localparam int BEAT_CTR_WIDTH = 5;

    // Wide enough for the largest supported requester count (8).
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    function automatic logic [PERF_CTR_WIDTH-1:0] sat_inc(input logic [PERF_CTR_WIDTH-1:0] v);
        return (v == {PERF_CTR_WIDTH{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular first-set finder: returns the first asserted request at or after start,
// wrapping modulo NUM_REQ (NUM_REQ must be a power of two).
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;

    // Rotate so start lands at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot_s = '0;
        off_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_s[i] = req[start + IDX_W'(i)];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IDX_W'(i) : off_s;
        end
        found = |rot_s;
        idx   = start + off_s;
    end

endmodule

// File: rtl/fifo_enq_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NUM_REQ requesters, with
// stall-hold and burst-lock. Define ARB_PERF_CTR_EN to add per-requester beat counters.
module fifo_enq_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_aL,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic                                    fifo_ready_enq,
    output logic                                    fifo_valid_enq,
    output logic [DATA_WIDTH-1:0]                   fifo_data_enq,
    output logic [$clog2(NUM_REQ)-1:0]              grant_id
`ifdef ARB_PERF_CTR_EN
    ,
    output logic [NUM_REQ*PERF_CTR_WIDTH-1:0]       perf_grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [BEAT_CTR_WIDTH-1:0] beat_ctr_q, beat_ctr_d;

    logic             any_valid_s;
    logic             hs_s;
    logic             owner_valid_s;
    logic             release_s;
    logic             new_beat_s;
    logic [IDX_W-1:0] scan_start_s;
    logic             pick_found_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [IDX_W-1:0] grant_s;

    assign any_valid_s    = |req_valid;
    assign hs_s           = any_valid_s & fifo_ready_enq;
    assign fifo_valid_enq = any_valid_s;

    // A burst owner that drops valid releases immediately; the scan then restarts past it.
    always_comb begin
        owner_valid_s = req_valid[owner_q];
        release_s     = (state_q == BURST) && !owner_valid_s;
        scan_start_s  = release_s ? (owner_q + IDX_W'(1)) : rr_ptr_q;
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .start (scan_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Grant selection: HOLD freezes the owner, BURST prefers it while it stays valid.
    always_comb begin
        grant_s = '0;
        case (state_q)
            IDLE:    grant_s = pick_found_s ? pick_idx_s : '0;
            HOLD:    grant_s = owner_q;
            BURST:   grant_s = owner_valid_s ? owner_q : (pick_found_s ? pick_idx_s : '0);
            default: grant_s = '0;
        endcase
    end

    // Handshake-facing outputs.
    always_comb begin
        req_ready = '0;
        if (hs_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        grant_id      = any_valid_s ? grant_s : '0;
        fifo_data_enq = req_data[grant_s];
    end

    // Next-state logic; new_beat_s marks the first accepted beat of a fresh grant.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_ctr_d = beat_ctr_q;
        new_beat_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    new_beat_s = 1'b1;
                end else if (any_valid_s) begin
                    owner_d = grant_s;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hs_s) begin
                    new_beat_s = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            BURST: begin
                if (owner_valid_s) begin
                    if (!hs_s) begin
                        state_d = BURST;
                    end else if (beat_ctr_q == BEAT_CTR_WIDTH'(BURST_LEN - 1)) begin
                        rr_ptr_d   = owner_q + IDX_W'(1);
                        beat_ctr_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_ctr_d = beat_ctr_q + BEAT_CTR_WIDTH'(1);
                    end
                end else begin
                    rr_ptr_d   = owner_q + IDX_W'(1);
                    beat_ctr_d = '0;
                    if (hs_s) begin
                        new_beat_s = 1'b1;
                    end else if (any_valid_s) begin
                        owner_d = grant_s;
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (new_beat_s && (BURST_LEN == 1)) begin
            rr_ptr_d = grant_s + IDX_W'(1);
            state_d  = IDLE;
        end else if (new_beat_s) begin
            owner_d    = grant_s;
            beat_ctr_d = BEAT_CTR_WIDTH'(1);
            state_d    = BURST;
        end else begin
            owner_d = owner_d;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_ctr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_ctr_q <= beat_ctr_d;
        end
    end

`ifdef ARB_PERF_CTR_EN
    logic [NUM_REQ-1:0][PERF_CTR_WIDTH-1:0] perf_cnt_q, perf_cnt_d;

    // Saturating accepted-beat count per requester.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_s && (grant_s == IDX_W'(i))) begin
                perf_cnt_d[i] = sat_inc(perf_cnt_q[i]);
            end else begin
                perf_cnt_d[i] = perf_cnt_q[i];
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_grant_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_enq_rr_arbiter.sv
// Directed self-checking bench: dut_a uses BURST_LEN=1, dut_b uses BURST_LEN=4, both share stimulus.
module tb_fifo_enq_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_aL;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_data;
    logic             fifo_ready_enq;

    logic [3:0]  rdy_a, rdy_b;
    logic        fv_a, fv_b;
    logic [31:0] fd_a, fd_b;
    logic [1:0]  gid_a, gid_b;
`ifdef ARB_PERF_CTR_EN
    logic [63:0] perf_a, perf_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_enq_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .BURST_LEN(1)) dut_a (
        .clk            (clk),
        .rst_aL         (rst_aL),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (rdy_a),
        .fifo_ready_enq (fifo_ready_enq),
        .fifo_valid_enq (fv_a),
        .fifo_data_enq  (fd_a),
        .grant_id       (gid_a)
`ifdef ARB_PERF_CTR_EN
        ,
        .perf_grant_cnt (perf_a)
`endif
    );

    fifo_enq_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .BURST_LEN(4)) dut_b (
        .clk            (clk),
        .rst_aL         (rst_aL),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (rdy_b),
        .fifo_ready_enq (fifo_ready_enq),
        .fifo_valid_enq (fv_b),
        .fifo_data_enq  (fd_b),
        .grant_id       (gid_b)
`ifdef ARB_PERF_CTR_EN
        ,
        .perf_grant_cnt (perf_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy);
        req_valid      = v;
        fifo_ready_enq = rdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_aL         = 1'b0;
        req_valid      = 4'b0000;
        fifo_ready_enq = 1'b1;
        tick();
        tick();
        rst_aL = 1'b1;
    endtask

    task automatic expect_a(input string tag, input logic [1:0] g, input logic [3:0] r);
        check_eq({tag, "_gid_a"}, {30'd0, gid_a}, {30'd0, g});
        check_eq({tag, "_rdy_a"}, {28'd0, rdy_a}, {28'd0, r});
    endtask

    task automatic expect_b(input string tag, input logic [1:0] g, input logic [3:0] r);
        check_eq({tag, "_gid_b"}, {30'd0, gid_b}, {30'd0, g});
        check_eq({tag, "_rdy_b"}, {28'd0, rdy_b}, {28'd0, r});
    endtask

    initial begin
        logic [1:0] g;
        logic [3:0] oh;

        for (int i = 0; i < 4; i++) begin
            req_data[i] = 32'hCAFE_0000 + i;
        end

        // Reset state: nothing valid, so nothing granted.
        do_reset();
        drive(4'b0000, 1'b1);
        check_eq("rst_fv", {31'd0, fv_a}, 32'd0);
        expect_a("rst", 2'd0, 4'b0000);
        tick();

        // Test 1: all valid, pure round-robin.
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1);
            g  = 2'(k % 4);
            oh = 4'b0001 << g;
            expect_a("t1", g, oh);
            check_eq("t1_data", fd_a, 32'hCAFE_0000 + {30'd0, g});
            tick();
        end

        // Test 2: stall freezes grant on 1 even when req 0 rises.
        do_reset();
        drive(4'b0110, 1'b0);
        expect_a("t2_stall0", 2'd1, 4'b0000);
        check_eq("t2_fv", {31'd0, fv_a}, 32'd1);
        tick();
        drive(4'b0111, 1'b0);
        expect_a("t2_stall1", 2'd1, 4'b0000);
        tick();
        drive(4'b0111, 1'b0);
        expect_a("t2_stall2", 2'd1, 4'b0000);
        tick();
        drive(4'b0111, 1'b1);
        expect_a("t2_accept", 2'd1, 4'b0010);
        check_eq("t2_data", fd_a, 32'hCAFE_0001);
        tick();
        drive(4'b0101, 1'b1);
        expect_a("t2_next", 2'd2, 4'b0100);
        tick();
        drive(4'b0001, 1'b1);
        expect_a("t2_wrap", 2'd0, 4'b0001);
        tick();

        // Test 3: BURST_LEN=4, requesters 2 and 3 alternate in 4-beat bursts.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(4'b1100, 1'b1);
            g  = (k < 4) ? 2'd2 : ((k < 8) ? 2'd3 : 2'd2);
            oh = 4'b0001 << g;
            expect_b("t3", g, oh);
            tick();
        end

        // Test 4a: owner 2 drops after 2 beats, req 3 idle -> grant 0 same cycle.
        do_reset();
        drive(4'b0100, 1'b1);
        expect_b("t4a_b1", 2'd2, 4'b0100);
        tick();
        drive(4'b0101, 1'b1);
        expect_b("t4a_b2", 2'd2, 4'b0100);
        tick();
        drive(4'b0001, 1'b1);
        expect_b("t4a_rel", 2'd0, 4'b0001);
        tick();

        // Test 4b: same, but req 3 valid -> grant 3 same cycle.
        do_reset();
        drive(4'b0100, 1'b1);
        expect_b("t4b_b1", 2'd2, 4'b0100);
        tick();
        drive(4'b1101, 1'b1);
        expect_b("t4b_b2", 2'd2, 4'b0100);
        tick();
        drive(4'b1001, 1'b1);
        expect_b("t4b_rel", 2'd3, 4'b1000);
        tick();

        // Test 5: reset mid-burst (owner 3, beat 2) discards the burst.
        do_reset();
        drive(4'b1000, 1'b1);
        tick();
        drive(4'b1000, 1'b1);
        tick();
        rst_aL = 1'b0;
        drive(4'b1111, 1'b1);
        tick();
        rst_aL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1);
            g  = (k < 4) ? 2'd0 : 2'd1;
            oh = 4'b0001 << g;
            expect_b("t5", g, oh);
            if (k == 0) begin
                expect_a("t5_first", 2'd0, 4'b0001);
            end else begin
                g = g;
            end
            tick();
        end

`ifdef ARB_PERF_CTR_EN
        // Test 6: per-requester counting and saturation.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(4'b0010, 1'b1);
            tick();
        end
        check_eq("t6_cnt1", {16'd0, perf_a[31:16]}, 32'd10);
        check_eq("t6_cnt0", {16'd0, perf_a[15:0]}, 32'd0);
        check_eq("t6_cnt2", {16'd0, perf_a[47:32]}, 32'd0);
        check_eq("t6_cnt3", {16'd0, perf_a[63:48]}, 32'd0);
        drive(4'b0010, 1'b1);
        for (int k = 0; k < 70000; k++) begin
            tick();
        end
        check_eq("t6_sat", {16'd0, perf_a[31:16]}, 32'h0000_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
